// File: rtl/sha256_pkg.sv
// Shared SHA-256 controller definitions: FSM states, round count, index width
// and the round where W(t) switches from message words to the schedule recurrence.
package sha256_pkg;

  localparam int NUM_ROUNDS   = 64;
  localparam int ROUND_W      = 6;
  localparam int SCHED_THRESH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: IDLE -> LOAD -> NUM_ROUNDS x ROUND -> FINAL -> DONE, start-to-done 67 cycles.
// stall freezes round progress one cycle after it is sampled; every output is a flop.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int ROUND_W    = sha256_pkg::ROUND_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  output logic               rom_rd,
  output logic [ROUND_W-1:0] rom_addr,
  output logic               load_init,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               w_sel,
  output logic               final_add,
  output logic               busy,
  output logic               done
);
  import sha256_pkg::*;

  localparam logic [ROUND_W-1:0] LAST_IDX  = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] SCHED_IDX = ROUND_W'(SCHED_THRESH);

  state_t             r_state;
  logic [ROUND_W-1:0] r_cnt;
  logic [ROUND_W-1:0] r_addr;
  logic               r_rd;
  logic               r_load;
  logic               r_round;
  logic               r_wsel;
  logic               r_final;
  logic               r_busy;
  logic               r_done;

  logic [ROUND_W-1:0] w_cnt_nxt;
  logic [ROUND_W-1:0] w_addr_nxt;
  logic               w_more;
  logic               w_fin;

  // cnt advances only on a cycle that actually executed a round
  assign w_cnt_nxt  = r_round ? r_cnt + 1'b1 : r_cnt;
  assign w_addr_nxt = w_cnt_nxt + 1'b1;
  assign w_more     = (w_cnt_nxt != LAST_IDX);
  assign w_fin      = r_round && (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_load  <= 1'b0;
      r_round <= 1'b0;
      r_wsel  <= 1'b0;
      r_final <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd    <= 1'b0;
      r_load  <= 1'b0;
      r_round <= 1'b0;
      r_final <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b1;
            r_load  <= 1'b1;
            r_wsel  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD, ST_ROUND: begin
          if (w_fin) begin
            r_state <= ST_FINAL;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wsel  <= 1'b0;
            r_final <= 1'b1;
          end else begin
            // a held cycle leaves rom_addr alone so K(cnt) stays on the ROM output
            r_state <= ST_ROUND;
            r_cnt   <= w_cnt_nxt;
            r_round <= !stall;
            r_rd    <= !stall && w_more;
            r_wsel  <= (w_cnt_nxt >= SCHED_IDX);
            if (!stall && w_more) r_addr <= w_addr_nxt;
          end
        end
        ST_FINAL: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_addr  <= '0;
          r_wsel  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_rd    = r_rd;
  assign rom_addr  = r_addr;
  assign load_init = r_load;
  assign round_en  = r_round;
  assign round_idx = r_cnt;
  assign w_sel     = r_wsel;
  assign final_add = r_final;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
